// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl
// ---------------------------------------------------------------------------
// Watches the output of a RAM ECC decoder and does two jobs:
//   1. Scrubbing: every correctable (single-bit) error produces a write-back
//      request that carries the corrected word to the RAM write port.
//   2. Error bookkeeping: the block counts correctable and uncorrectable
//      errors, latches the address of the first error, and keeps sticky
//      flags for uncorrectable errors and for dropped write-backs.
//
// Ports
//   clk, rst         sole clock; synchronous active-high reset
//   rd_valid         a decoded word (rd_addr/rd_data/flags) is present
//   rd_addr          address of the decoded word
//   rd_data          corrected data from the decoder
//   single_error     decoder single-error flag
//   double_error     decoder double-error flag ({1,1} is invalid -> DED)
//   clr              one-cycle pulse; clears counters and sticky status
//   wb_ack           the RAM write port accepted the pending write-back
//   wb_req           a write-back is pending
//   wb_addr/wb_data  address and corrected data of the pending write-back
//   sec_cnt          saturating count of correctable errors
//   ded_cnt          saturating count of uncorrectable/invalid errors
//   first_err_addr   address of the first error since reset/clr
//   first_err_valid  first_err_addr holds a captured address
//   ded_irq          sticky uncorrectable-error flag
//   wb_ovf           sticky flag: a write-back had to be dropped
// ---------------------------------------------------------------------------
module ecc_scrub_ctrl #(
  parameter int P_DATAWIDTH = 32,
  parameter int P_ADDRWIDTH = 10,
  parameter int P_CNTWIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_valid,
  input  logic [P_ADDRWIDTH-1:0] rd_addr,
  input  logic [P_DATAWIDTH-1:0] rd_data,
  input  logic                   single_error,
  input  logic                   double_error,
  input  logic                   clr,
  input  logic                   wb_ack,
  output logic                   wb_req,
  output logic [P_ADDRWIDTH-1:0] wb_addr,
  output logic [P_DATAWIDTH-1:0] wb_data,
  output logic [P_CNTWIDTH-1:0]  sec_cnt,
  output logic [P_CNTWIDTH-1:0]  ded_cnt,
  output logic [P_ADDRWIDTH-1:0] first_err_addr,
  output logic                   first_err_valid,
  output logic                   ded_irq,
  output logic                   wb_ovf
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } wb_state_t;

  localparam logic [P_CNTWIDTH-1:0] CNT_MAX = '1;
  localparam logic [P_CNTWIDTH-1:0] CNT_ONE = P_CNTWIDTH'(1);

  wb_state_t state;
  wb_state_t state_next;

  logic wb_load;
  logic ovf_set;

  logic sec_event;
  logic ded_event;

  logic [P_CNTWIDTH-1:0]  sec_cnt_next;
  logic [P_CNTWIDTH-1:0]  ded_cnt_next;
  logic [P_ADDRWIDTH-1:0] first_err_addr_next;
  logic                   first_err_valid_next;
  logic                   ded_irq_next;
  logic                   wb_ovf_next;

  // Flags only mean something while rd_valid is high. The invalid {1,1}
  // combination is folded into the uncorrectable class, so it never scrubs.
  assign sec_event = rd_valid & single_error & ~double_error;
  assign ded_event = rd_valid & double_error;

  assign wb_req = (state == REQ);

  // Write-back state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Write-back next state. An ack and a new correctable error in the same
  // cycle hand over straight to the new request without an idle gap; a new
  // error while the port is still busy is dropped and flagged instead.
  always_comb begin
    state_next = state;
    wb_load    = 1'b0;
    ovf_set    = 1'b0;
    case (state)
      IDLE: begin
        if (sec_event) begin
          state_next = REQ;
          wb_load    = 1'b1;
        end
      end
      REQ: begin
        if (wb_ack) begin
          if (sec_event) begin
            wb_load = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (sec_event) begin
          ovf_set = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Write-back payload; only reloaded when a new request is accepted, so it
  // stays stable while a request waits for its ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_addr <= '0;
      wb_data <= '0;
    end else if (wb_load) begin
      wb_addr <= rd_addr;
      wb_data <= rd_data;
    end
  end

  // Status next values. clr is applied first and the current event on top
  // of the cleared values, so an event coinciding with clr is not lost.
  always_comb begin
    sec_cnt_next         = clr ? '0 : sec_cnt;
    ded_cnt_next         = clr ? '0 : ded_cnt;
    first_err_valid_next = clr ? 1'b0 : first_err_valid;
    first_err_addr_next  = first_err_addr;
    ded_irq_next         = clr ? 1'b0 : ded_irq;
    wb_ovf_next          = clr ? 1'b0 : wb_ovf;

    if (sec_event && (sec_cnt_next != CNT_MAX)) begin
      sec_cnt_next = sec_cnt_next + CNT_ONE;
    end
    if (ded_event) begin
      ded_irq_next = 1'b1;
      if (ded_cnt_next != CNT_MAX) begin
        ded_cnt_next = ded_cnt_next + CNT_ONE;
      end
    end
    if ((sec_event || ded_event) && !first_err_valid_next) begin
      first_err_addr_next  = rd_addr;
      first_err_valid_next = 1'b1;
    end
    if (ovf_set) begin
      wb_ovf_next = 1'b1;
    end
  end

  // Status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_cnt         <= '0;
      ded_cnt         <= '0;
      first_err_addr  <= '0;
      first_err_valid <= 1'b0;
      ded_irq         <= 1'b0;
      wb_ovf          <= 1'b0;
    end else begin
      sec_cnt         <= sec_cnt_next;
      ded_cnt         <= ded_cnt_next;
      first_err_addr  <= first_err_addr_next;
      first_err_valid <= first_err_valid_next;
      ded_irq         <= ded_irq_next;
      wb_ovf          <= wb_ovf_next;
    end
  end

endmodule

// File: doc/ecc_scrub_ctrl.md
ECC_SCRUB_CTRL -- requirements
Module: ecc_scrub_ctrl

Interface
REQ-001 SHALL have parameter P_DATAWIDTH, default 32, width of decoded data word.
REQ-002 SHALL have parameter P_ADDRWIDTH, default 10, RAM word address width.
REQ-003 SHALL have parameter P_CNTWIDTH, default 16, width of each error counter.
REQ-004 SHALL use a single clock and a synchronous, active-high reset:
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- rd_valid  in  1  decoded read word present this cycle
- rd_addr  in  P_ADDRWIDTH  address of the decoded word
- rd_data  in  P_DATAWIDTH  corrected data from the ECC decoder
- single_error  in  1  decoder single-error flag
- double_error  in  1  decoder double-error flag
- clr  in  1  one-cycle pulse, clears counters and sticky status
- wb_ack  in  1  RAM write port accepted the write-back
- wb_req  out  1  write-back request pending
- wb_addr  out  P_ADDRWIDTH  write-back address
- wb_data  out  P_DATAWIDTH  corrected write-back data (re-encoded by the RAM write port)
- sec_cnt  out  P_CNTWIDTH  corrected-error count
- ded_cnt  out  P_CNTWIDTH  uncorrectable-error count (double and invalid)
- first_err_addr  out  P_ADDRWIDTH  address of first error since reset/clr
- first_err_valid  out  1  first_err_addr holds a captured address
- ded_irq  out  1  sticky, set on any uncorrectable event
- wb_ovf  out  1  sticky, set when a write-back is dropped

Function
REQ-005 SHALL sample inputs only when rd_valid=1; flags ignored when rd_valid=0.
REQ-006 SHALL classify {single_error,double_error}: 00 clean; 10 correctable (SEC); 01 uncorrectable (DED); 11 invalid, treated as DED.
REQ-007 SHALL increment sec_cnt on SEC and ded_cnt on DED/invalid one cycle after the rd_valid cycle; counters saturate at all-ones.
REQ-008 SHALL set ded_irq one cycle after a DED/invalid event; it holds until clr or rst.
REQ-009 SHALL capture rd_addr into first_err_addr and set first_err_valid on the first SEC/DED/invalid event while first_err_valid=0; later events SHALL not overwrite.
REQ-010 SHALL implement write-back FSM with states IDLE and REQ; wb_req=1 exactly in REQ.
REQ-011 IDLE + SEC event -> REQ next cycle with wb_addr=rd_addr, wb_data=rd_data.
REQ-012 REQ + wb_ack=1 and no SEC event -> IDLE next cycle; wb_addr/wb_data SHALL stay stable while wb_req=1 and wb_ack=0.
REQ-013 REQ + wb_ack=1 + SEC event same cycle -> stay REQ, load new addr/data (back-to-back, no gap cycle).
REQ-014 REQ + wb_ack=0 + SEC event -> new write-back dropped, wb_ovf set next cycle, pending request unchanged.
REQ-015 DED/invalid events SHALL never generate a write-back.
REQ-016 clr SHALL zero sec_cnt, ded_cnt, first_err_valid, ded_irq, wb_ovf next cycle; SHALL not affect FSM or pending write-back.
REQ-017 clr coincident with an event: clear applied first, then event; e.g. SEC with clr -> sec_cnt=1, first_err_valid=1 with that address.
REQ-018 wb_ack while IDLE SHALL be ignored.

Reset
REQ-019 rst SHALL force, next edge: FSM IDLE, wb_req=0, wb_addr=0, wb_data=0, sec_cnt=0, ded_cnt=0, first_err_addr=0, first_err_valid=0, ded_irq=0, wb_ovf=0.
REQ-020 rst mid-write-back SHALL abandon the pending request with no write-back issued afterwards; rst overrides clr and all events in the same cycle.

Verification
REQ-021 rd_valid=1, addr=0x012, data=0xDEADBEEF, flags 10, wb_ack held 0 -> next cycle wb_req=1, wb_addr=0x012, wb_data=0xDEADBEEF, sec_cnt=1, first_err_addr=0x012; stable until wb_ack, then wb_req=0 next cycle.
REQ-022 Flags 01 at addr 0x3FF, then flags 11 at 0x001 -> ded_cnt=2, ded_irq=1, first_err_addr=0x3FF, wb_req never 1.
REQ-023 SEC at 0x010 pending, SEC at 0x020 with wb_ack=1 same cycle -> wb_req stays 1, wb_addr=0x020; SEC at 0x030 with wb_ack=0 -> wb_ovf=1, wb_addr still 0x020.
REQ-024 P_CNTWIDTH=4, 17 SEC events -> sec_cnt=0xF; clr coincident with one more SEC -> sec_cnt=1.
REQ-025 rst asserted while wb_req=1 -> all outputs 0 next cycle; wb_req stays 0 with no further events.
REQ-026 rd_valid=0 with flags 11 for 10 cycles -> no counter, flag or wb_req change.
